// File: rtl/instr_encoder_pkg.sv
// Shared types for the MIPS32 instruction encoder: decoded operation codes
// and the encoder sequencer state (exported for debug visibility).
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_LUI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_MULT, OP_DIV, OP_JR, OP_BEQ
  } oper_t;

  typedef enum logic [1:0] {
    IDLE, EMIT_LUI, EMIT_ORI, EMIT_OP
  } enc_state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder.
// Both channels use strict valid/ready: a transfer happens on a clock edge where
// valid & ready are both high; the sender holds its payload stable while valid & !ready.
interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  oper_t       req_op;
  logic        req_use_imm;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err_pulse;
  logic        busy;
  enc_state_t  dbg_state;

  modport master (
    output req_valid, req_op, req_use_imm, req_rs, req_rt, req_rd, req_shamt, req_imm,
    output out_ready,
    input  req_ready, out_valid, out_instr, out_last, err_pulse, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_op, req_use_imm, req_rs, req_rt, req_rd, req_shamt, req_imm,
    input  out_ready,
    output req_ready, out_valid, out_instr, out_last, err_pulse, busy, dbg_state
  );

endinterface

// File: rtl/instr_encoder.sv
// Encodes decoded operations into MIPS32 words, expanding wide immediates via $at
// into LUI/ORI/op. Optional macro ENCODER_SKIP_ORI_EN drops the ORI when imm[15:0]==0.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  enc_state_t  state, state_nx;
  logic [31:0] lui_q, ori_q, op_q;
  logic [31:0] lui_w, ori_w, op_w;
  logic        cls_err, cls_expand;
  logic [5:0]  funct, iopc, mopc;
  logic        is_alu, zext, is_load, is_store;
  logic        sfit, zfit;
  logic        accept, push, push_last, pop, can_push, full, empty, skip_ori;
  logic [31:0] push_word;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [32:0] mem [FIFO_DEPTH];
  logic        err_q;

  // ALU ops: R-type funct plus the matching I-type opcode (0 = no immediate form).
  always_comb begin
    funct  = 6'h00;
    iopc   = 6'h00;
    zext   = 1'b0;
    is_alu = 1'b1;
    case (bus.req_op)
      OP_ADDU: begin funct = 6'h21; iopc = 6'h09; end
      OP_SUBU: funct = 6'h23;
      OP_AND:  begin funct = 6'h24; iopc = 6'h0C; zext = 1'b1; end
      OP_OR:   begin funct = 6'h25; iopc = 6'h0D; zext = 1'b1; end
      OP_XOR:  begin funct = 6'h26; iopc = 6'h0E; zext = 1'b1; end
      OP_NOR:  funct = 6'h27;
      OP_SLT:  begin funct = 6'h2A; iopc = 6'h0A; end
      OP_SLTU: begin funct = 6'h2B; iopc = 6'h0B; end
      default: is_alu = 1'b0;
    endcase
  end

  always_comb begin
    mopc     = 6'h00;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (bus.req_op)
      OP_LB:   begin mopc = 6'h20; is_load = 1'b1; end
      OP_LH:   begin mopc = 6'h21; is_load = 1'b1; end
      OP_LW:   begin mopc = 6'h23; is_load = 1'b1; end
      OP_LBU:  begin mopc = 6'h24; is_load = 1'b1; end
      OP_LHU:  begin mopc = 6'h25; is_load = 1'b1; end
      OP_SB:   begin mopc = 6'h28; is_store = 1'b1; end
      OP_SH:   begin mopc = 6'h29; is_store = 1'b1; end
      OP_SW:   begin mopc = 6'h2B; is_store = 1'b1; end
      default: ;
    endcase
  end

  assign sfit  = (&bus.req_imm[31:15]) | ~(|bus.req_imm[31:15]);
  assign zfit  = ~(|bus.req_imm[31:16]);
  assign lui_w = {6'h0F, 5'd0, 5'd1, bus.req_imm[31:16]};
  assign ori_w = {6'h0D, 5'd1, 5'd1, bus.req_imm[15:0]};

  always_comb begin
    op_w       = '0;
    cls_err    = 1'b0;
    cls_expand = 1'b0;
    if (is_alu) begin
      if (!bus.req_use_imm)
        op_w = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, funct};
      else if (iopc == 6'h00)
        cls_err = 1'b1;
      else if (zext ? zfit : sfit)
        op_w = {iopc, bus.req_rs, bus.req_rd, bus.req_imm[15:0]};
      else if (bus.req_rs == 5'd1)
        cls_err = 1'b1;  // $at is the scratch register of the expansion
      else begin
        cls_expand = 1'b1;
        op_w       = {6'h00, bus.req_rs, 5'd1, bus.req_rd, 5'd0, funct};
      end
    end else if (is_load || is_store) begin
      if (!sfit)
        cls_err = 1'b1;
      else
        op_w = {mopc, bus.req_rs, (is_load ? bus.req_rd : bus.req_rt), bus.req_imm[15:0]};
    end else begin
      case (bus.req_op)
        OP_SLL:  op_w = {11'd0, bus.req_rt, bus.req_rd, bus.req_shamt, 6'h00};
        OP_SRL:  op_w = {11'd0, bus.req_rt, bus.req_rd, bus.req_shamt, 6'h02};
        OP_SRA:  op_w = {11'd0, bus.req_rt, bus.req_rd, bus.req_shamt, 6'h03};
        OP_LUI:  op_w = {6'h0F, 5'd0, bus.req_rd, bus.req_imm[15:0]};
        default: cls_err = 1'b1;
      endcase
    end
  end

`ifdef ENCODER_SKIP_ORI_EN
  assign skip_ori = (ori_q[15:0] == 16'h0000);
`else
  assign skip_ori = 1'b0;
`endif

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop      = !empty && bus.out_ready;
  assign can_push = !full || pop;
  assign accept   = bus.req_valid && (state == IDLE);

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !cls_err) state_nx = cls_expand ? EMIT_LUI : EMIT_OP;
      end
      EMIT_LUI: begin
        if (can_push) begin
          push      = 1'b1;
          push_word = lui_q;
          state_nx  = skip_ori ? EMIT_OP : EMIT_ORI;
        end
      end
      EMIT_ORI: begin
        if (can_push) begin
          push      = 1'b1;
          push_word = ori_q;
          state_nx  = EMIT_OP;
        end
      end
      EMIT_OP: begin
        if (can_push) begin
          push      = 1'b1;
          push_word = op_q;
          push_last = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= accept && cls_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lui_q <= '0;
      ori_q <= '0;
      op_q  <= '0;
    end else if (accept) begin
      lui_q <= lui_w;
      ori_q <= ori_w;
      op_q  <= op_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {push_last, push_word};
  end

  assign bus.req_ready                 = (state == IDLE);
  assign bus.out_valid                 = !empty;
  assign {bus.out_last, bus.out_instr} = empty ? 33'd0 : mem[rd_ptr[AW-1:0]];
  assign bus.err_pulse                 = err_q;
  assign bus.busy                      = (state != IDLE) || !empty;
  assign bus.dbg_state                 = state;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Turns decoded operations (oper_t op plus register and immediate fields) back into MIPS32 instruction words. It is the encode side of the decode path.
- Accepts one request per valid/ready handshake and expands 32-bit immediates that do not fit into a LUI/ORI/op sequence through $at.
- Streams the resulting words from an internal FIFO.
- Used by the debug instruction-injection path and by testbench stimulus feeding fetch.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  $bits(oper_t)  operation to encode
req_use_imm  in  1  second operand is req_imm rather than req_rt
req_rs  in  5  source register / load-store base
req_rt  in  5  second source register / store data
req_rd  in  5  destination register
req_shamt  in  5  shift amount
req_imm  in  32  immediate / offset
out_valid  out  1  out_instr valid
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction word
out_last  out  1  word is the final word of its request
err_pulse  out  1  one-cycle pulse: request dropped as unencodable
busy  out  1  sequencer not IDLE or FIFO not empty

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and the FIFO is flushed.
  - req_ready=1, out_valid=0, out_instr=0, out_last=0, err_pulse=0, busy=0.
  - Reset applied mid-expansion discards all pending words.
- States: IDLE, EMIT_LUI, EMIT_ORI, EMIT_OP. req_ready=1 only in IDLE.
- IDLE accept (cycle N): fields are latched and classified.
  - Unsupported: err_pulse=1 at N+1, nothing emitted, stay IDLE.
  - Otherwise go to EMIT_LUI if expansion is needed, else EMIT_OP.
- Push rule: each EMIT state pushes one word when FIFO is not full (a pop in the same cycle frees a slot), then advances. It holds while the FIFO is full.
  - EMIT_LUI -> EMIT_ORI -> EMIT_OP -> IDLE.
  - out_last is set only on the EMIT_OP word.
- Latency: first word is visible on out_valid at N+2 (registered FIFO output).
  - Throughput is one word/cycle with out_ready=1.
  - A back-to-back single-word request is accepted at N+2.
- Output: out_instr/out_last stay stable while out_valid & !out_ready.
- R-type, use_imm=0 (opcode 0; fields rs, rt, rd): ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLTU 0x2B.
- Shifts (rs field=0, rt=req_rt, rd, shamt): SLL 0x00, SRL 0x02, SRA 0x03. req_use_imm is ignored.
- use_imm=1 (rt field=req_rd, imm16):
  - ADDU->ADDIU 0x09, SLT->SLTI 0x0A, SLTU->SLTIU 0x0B: fit if req_imm[31:15] is all-equal (sign-extends).
  - AND->ANDI 0x0C, OR->ORI 0x0D, XOR->XORI 0x0E: fit if req_imm[31:16]==0.
  - SUBU/NOR with imm: unsupported.
- Expansion (imm does not fit): emits three words.
  - LUI $1, imm[31:16]
  - ORI $1, $1, imm[15:0]
  - R-type op rd, rs, $1
  - Unsupported if req_rs==1.
- LUI: opcode 0x0F, rt=req_rd, imm16=req_imm[15:0].
- Loads LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25: base=rs, rt=req_rd, offset=req_imm[15:0].
- Stores SB 0x28, SH 0x29, SW 0x2B: base=rs, rt=req_rt, offset=req_imm[15:0].
- Load/store offset outside signed 16-bit range: unsupported.
- All other oper_t values: unsupported.
- FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro: ENCODER_SKIP_ORI_EN.
- Defined: in an expansion with req_imm[15:0]==0, EMIT_ORI is skipped; LUI is followed directly by the op (2 words).
- Undefined: expansion is always 3 words.

Test Plan:
- ADDU rs=2 rt=4 rd=3 use_imm=0, out_ready=1 -> single word 0x00441821, out_last=1, out_valid 2 cycles after accept.
- ADDU rs=6 rd=5 use_imm=1 imm=0xFFFFFFFF -> 0x24C5FFFF.
- Same request with imm=0x12345678 -> 0x3C011234, 0x34215678, 0x00C12821; out_last only on the third word.
- Expansion with imm=0x00010000 -> 3 words without the macro; 0x3C010001 then 0x00C12821 with ENCODER_SKIP_ORI_EN.
- FIFO_DEPTH=2, out_ready=0, issue the imm=0x12345678 expansion -> FIFO fills and the sequencer stalls in EMIT_OP with req_ready=0. Then out_ready=1 -> three words in order, no loss or duplication, then req_ready=1.
- Error and reset cases:
  - LW rs=29 rd=8 imm=0xFFFFFFFC -> 0x8FA8FFFC.
  - LW with imm=0x00010000 -> err_pulse one cycle, no output.
  - OP_MULT -> err_pulse.
  - rst_n low mid-expansion -> out_valid=0, busy=0, req_ready=1 immediately.
